gray_step_counter: RTL and testbench

Sequential source stage for the binary-to-Gray encoding path. Holds a WIDTH-bit binary count that steps up or down or loads a value, and registers the matching Gray code alongside it. Each new value is presented on a valid/ready output handshake, so a downstream consumer can throttle the count. It is the upstream feeder that supplies binary values and their Gray equivalents to the encoder-based datapath and its checkers.

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_encode.sv | 12 +
 rtl/gray_step_counter.sv | 109 ++++++++++
 tb/tb_gray_step_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray step counter: default width, FSM state
// encoding and a reference binary-to-Gray conversion.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Binary-to-Gray on the widest legal count; callers take the low bits.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray converter, parameterised on WIDTH.
module gray_encode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Each Gray bit is the XOR of a binary bit and its upper neighbour.
  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_step_counter.sv
// Up/down/load binary counter with a registered Gray copy, presented on a
// valid/ready handshake. Optional macro GRAY_STEP_CHECK_EN adds a sticky
// error flag raised when an en-step moves the Gray code by other than one bit.
//
// state | meaning
// IDLE  | no unconsumed value; out_valid=0, any request updates
// HOLD  | value presented; out_valid=1, updates only when out_ready
module gray_step_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_next;
  logic             upd;
  logic             wrap_d, wrap_q;

  gray_encode #(.WIDTH(WIDTH)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_next)
  );

  // Next-state, next count and wrap detection; load beats en, stall in HOLD.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    upd     = 1'b0;
    wrap_d  = 1'b0;
    if (state_q == IDLE || out_ready) begin
      if (load) begin
        bin_d = load_val;
        upd   = 1'b1;
      end else if (en) begin
        upd    = 1'b1;
        bin_d  = dir ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        wrap_d = dir ? (&bin_q) : ~(|bin_q);
      end
    end
    if (upd) begin
      state_d = HOLD;
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  // State, count and Gray registers; reset discards any pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      if (upd) begin
        bin_q  <= bin_d;
        gray_q <= gray_next;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign wrap      = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
  logic err_q;
  logic step_chk;

  function automatic logic [4:0] popcnt(input logic [WIDTH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Loads may jump arbitrarily, so only en-steps are checked.
  assign step_chk = upd & ~load;

  // Sticky adjacency error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (step_chk && popcnt(gray_q ^ gray_next) != 5'd1) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_counter.sv
// Self-checking bench for gray_step_counter: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the counter.
module tb_gray_step_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, dir, load, out_ready;
  logic [W-1:0] load_val;
  logic         out_valid, wrap, err;
  logic [W-1:0] bin_q, gray_q;

  int checks   = 0;
  int failures = 0;

  int m_bin;
  bit m_valid, m_wrap;

  gray_step_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_q     (bin_q),
    .gray_q    (gray_q),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic drive(input bit r, input bit e, input bit d, input bit l,
                       input int lv, input bit rdy);
    rst       = r;
    en        = e;
    dir       = d;
    load      = l;
    load_val  = W'(lv);
    out_ready = rdy;
  endtask

  // Model of one clock edge, using the inputs currently applied.
  task automatic model_edge();
    bit allowed;
    allowed = !m_valid || out_ready;
    if (rst) begin
      m_bin = 0; m_valid = 0; m_wrap = 0;
    end else if (allowed && load) begin
      m_bin = int'(load_val); m_valid = 1; m_wrap = 0;
    end else if (allowed && en) begin
      m_wrap  = dir ? (m_bin == M - 1) : (m_bin == 0);
      m_bin   = dir ? (m_bin + 1) % M : (m_bin + M - 1) % M;
      m_valid = 1;
    end else begin
      m_wrap = 0;
      if (m_valid && out_ready) m_valid = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".bin"},   32'(bin_q),     32'(m_bin));
    check({tag, ".gray"},  32'(gray_q),    32'(to_gray(m_bin)));
    check({tag, ".wrap"},  32'(wrap),      32'(m_wrap));
    check({tag, ".err"},   32'(err),       32'd0);
  endtask

  initial begin
    int wraps;
    m_bin = 0; m_valid = 0; m_wrap = 0;
    drive(1, 0, 0, 0, 0, 0);
    #2;
    cycle();
    cycle();
    check_all("reset");

    // Full up sweep with wrap on the return to 0.
    wraps = 0;
    drive(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check_all("up");
      check("up_seq", 32'(bin_q), 32'((i + 1) % 16));
      if (wrap === 1'b1) wraps++;
    end
    check("up_wrap_count", 32'(wraps), 32'd1);

    // Down wrap from reset.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 0, 0, 0, 1);
    cycle();
    check_all("down");
    check("down_bin", 32'(bin_q), 32'd15);
    check("down_gray", 32'(gray_q), 32'd8);
    check("down_wrap", 32'(wrap), 32'd1);
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    check("down_wrap_pulse", 32'(wrap), 32'd0);

    // Backpressure: stall at 3, then resume at 4.
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 1, 0, 0, 1);
    repeat (3) cycle();
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_all("stall");
      check("stall_bin", 32'(bin_q), 32'd3);
      check("stall_gray", 32'(gray_q), 32'd2);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    drive(0, 1, 1, 0, 0, 1);
    cycle();
    check_all("resume");
    check("resume_bin", 32'(bin_q), 32'd4);
    check("resume_gray", 32'(gray_q), 32'd6);

    // Load wins over en.
    drive(0, 1, 1, 1, 10, 1);
    cycle();
    check_all("load");
    check("load_bin", 32'(bin_q), 32'd10);
    check("load_gray", 32'(gray_q), 32'd15);
    check("load_wrap", 32'(wrap), 32'd0);

    // Reset while holding a pending value.
    drive(0, 1, 1, 0, 0, 0);
    cycle();
    check_all("hold");
    drive(1, 1, 1, 0, 0, 0);
    cycle();
    check_all("mid_rst");
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    drive(0, 1, 1, 0, 0, 1);
    cycle();
    check_all("post_rst");
    check("post_rst_bin", 32'(bin_q), 32'd1);

    // Randomized traffic with interleaved loads and occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, M - 1)),
            $urandom_range(0, 3) != 0);
      cycle();
      check_all("rand");
    end

`ifdef GRAY_STEP_CHECK_EN
    // Corrupt the encoder output for one step; err must latch until reset.
    drive(0, 1, 1, 0, 0, 1);
    force dut.gray_next = ~dut.gray_q;
    @(posedge clk);
    #1;
    release dut.gray_next;
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("err_sticky", 32'(err), 32'd1);
    end
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    check("err_cleared", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
